// File: rtl/genie_conv_pkg.sv
// Shared helpers for the genie_conv forward and reverse field converters.
// conv_lookup() searches a packed key table for a value and returns the
// paired entry from a second packed table; the lowest matching index wins.
// Tables and values are zero-extended into fixed maximum-width containers, so
// callers must keep N_ENTRIES <= ConvMaxEntries and field widths <= ConvMaxW.
package genie_conv_pkg;

  localparam int unsigned ConvMaxEntries = 32;
  localparam int unsigned ConvMaxW       = 16;

  typedef logic [ConvMaxEntries*ConvMaxW-1:0] conv_table_t;
  typedef logic [ConvMaxW-1:0]                conv_val_t;

  typedef struct packed {
    logic      match;
    conv_val_t value;
  } conv_result_t;

  function automatic conv_val_t conv_mask(input int unsigned w);
    conv_val_t m;
    m = '0;
    for (int unsigned b = 0; b < ConvMaxW; b++) begin
      if (b < w) m[b] = 1'b1;
    end
    return m;
  endfunction

  // table_out holds the keys searched, table_in holds the values returned.
  function automatic conv_result_t conv_lookup(input conv_table_t table_in,
                                               input conv_table_t table_out,
                                               input conv_val_t   key,
                                               input int unsigned n_entries,
                                               input int unsigned w_in,
                                               input int unsigned w_out);
    conv_result_t res;
    conv_table_t  sh_in;
    conv_table_t  sh_out;
    conv_val_t    m_in;
    conv_val_t    m_out;
    res.match = 1'b0;
    res.value = '0;
    m_in      = conv_mask(w_in);
    m_out     = conv_mask(w_out);
    // Walk downward so the lowest matching index is written last and wins.
    for (int i = int'(ConvMaxEntries) - 1; i >= 0; i--) begin
      if (i < int'(n_entries)) begin
        sh_out = table_out >> (w_out * i);
        if ((sh_out[ConvMaxW-1:0] & m_out) == (key & m_out)) begin
          sh_in     = table_in >> (w_in * i);
          res.match = 1'b1;
          res.value = sh_in[ConvMaxW-1:0] & m_in;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/genie_skid_buf.sv
// Two-entry valid/ready register slice with a registered ready.
//   clk, reset : clock, synchronous active-high reset
//   i_data/i_valid/o_ready : upstream beat, accepted on i_valid && o_ready
//   o_data/o_valid/i_ready : downstream beat, consumed on o_valid && i_ready
// State is {skid_valid, main_valid}; o_ready is simply !skid_valid, which
// lets it come straight from a flop while still sustaining one beat/cycle.
module genie_skid_buf #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b01;
  localparam logic [1:0] StFull  = 2'b11;

  logic [1:0]   st_q, st_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         take;
  logic         pop;

  // Gated by reset so no upstream handshake completes while resetting.
  assign o_ready = ready_q && !reset;
  assign o_valid = st_q[0];
  assign o_data  = main_q;

  assign take = i_valid && o_ready;
  assign pop  = st_q[0] && i_ready;

  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    skid_d = skid_q;
    case (st_q)
      StEmpty: begin
        if (take) begin
          main_d = i_data;
          st_d   = StOne;
        end
      end
      StOne: begin
        if (take && pop) begin
          main_d = i_data;
        end else if (take) begin
          skid_d = i_data;
          st_d   = StFull;
        end else if (pop) begin
          st_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          main_d = skid_q;
          st_d   = StOne;
        end
      end
      default: st_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= StEmpty;
      ready_q <= 1'b1;
    end else begin
      st_q    <= st_d;
      ready_q <= !st_d[1];
    end
  end

  // Payload needs no reset: it is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule

// File: rtl/genie_conv_rev.sv
// Reverse field converter: maps a converted field (WOF bits) back to the
// original field (WIF bits) through the IF/OF table pair, then registers the
// beat in a two-entry skid buffer.
//   clk, reset                 : clock, synchronous active-high reset
//   i_data/i_field/i_valid     : input beat, accepted on i_valid && o_ready
//   o_data/o_field/o_valid     : registered output beat, consumed on i_ready
//   o_err/o_err_count          : sticky unmatched flag, saturating count
//   i_err_clear                : clears both error outputs (wins over a hit)
// Unmatched beats carry DEFAULT_IF, or are consumed and discarded when
// DROP_UNMATCHED is set.
module genie_conv_rev
  import genie_conv_pkg::*;
#(
  parameter int unsigned                WD             = 1,
  parameter int unsigned                WIF            = 1,
  parameter int unsigned                WOF            = 1,
  parameter int unsigned                N_ENTRIES      = 1,
  parameter logic [N_ENTRIES*WIF-1:0]   IF             = '0,
  parameter logic [N_ENTRIES*WOF-1:0]   OF             = '0,
  parameter logic [WIF-1:0]             DEFAULT_IF     = '0,
  parameter bit                         DROP_UNMATCHED = 1'b0,
  parameter int unsigned                WCNT           = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WD-1:0]   i_data,
  input  logic [WOF-1:0]  i_field,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [WD-1:0]   o_data,
  output logic [WIF-1:0]  o_field,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_err,
  output logic [WCNT-1:0] o_err_count,
  input  logic            i_err_clear
);

  conv_result_t    lut;
  logic [WIF-1:0]  field_rec;
  logic            accept;
  logic            unmatched_acc;
  logic            buf_valid;
  logic            err_q, err_d;
  logic [WCNT-1:0] cnt_q, cnt_d;
  logic            unused_lut;

  always_comb begin
    lut = conv_lookup(conv_table_t'(IF), conv_table_t'(OF), conv_val_t'(i_field),
                      N_ENTRIES, WIF, WOF);
  end

  assign field_rec     = lut.match ? lut.value[WIF-1:0] : DEFAULT_IF;
  assign accept        = i_valid && o_ready;
  assign unmatched_acc = accept && !lut.match;
  // A dropped beat still handshakes upstream but never reaches the buffer.
  assign buf_valid     = i_valid && (lut.match || !DROP_UNMATCHED);
  assign unused_lut    = ^lut.value;

  genie_skid_buf #(
    .W (WD + WIF)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_data  ({i_data, field_rec}),
    .i_valid (buf_valid),
    .o_ready (o_ready),
    .o_data  ({o_data, o_field}),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (i_err_clear) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (unmatched_acc) begin
      err_d = 1'b1;
      if (cnt_q != {WCNT{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_err       = err_q;
  assign o_err_count = cnt_q;

endmodule

// File: tb/tb_genie_conv_rev.sv
module tb_genie_conv_rev;

  logic       clk;
  logic       reset;
  logic [7:0] i_data;
  logic [1:0] i_field;
  logic       v0, v1;
  logic       i_ready;
  logic       i_err_clear;

  logic       o_ready0, o_valid0, o_err0;
  logic [7:0] o_data0;
  logic [3:0] o_field0;
  logic [1:0] o_cnt0;
  logic       o_ready1, o_valid1, o_err1;
  logic [7:0] o_data1;
  logic [3:0] o_field1;
  logic [1:0] o_cnt1;

  int tests = 0;
  int fails = 0;

  // Entry order LSB first: IF {3,5,C}, OF {1,2,1}.
  genie_conv_rev #(
    .WD (8), .WIF (4), .WOF (2), .N_ENTRIES (3),
    .IF (12'hC53), .OF (6'b01_10_01), .DEFAULT_IF (4'hF),
    .DROP_UNMATCHED (1'b0), .WCNT (2)
  ) dut0 (
    .clk (clk), .reset (reset), .i_data (i_data), .i_field (i_field),
    .i_valid (v0), .o_ready (o_ready0), .o_data (o_data0), .o_field (o_field0),
    .o_valid (o_valid0), .i_ready (i_ready), .o_err (o_err0),
    .o_err_count (o_cnt0), .i_err_clear (i_err_clear)
  );

  genie_conv_rev #(
    .WD (8), .WIF (4), .WOF (2), .N_ENTRIES (3),
    .IF (12'hC53), .OF (6'b01_10_01), .DEFAULT_IF (4'hF),
    .DROP_UNMATCHED (1'b1), .WCNT (2)
  ) dut1 (
    .clk (clk), .reset (reset), .i_data (i_data), .i_field (i_field),
    .i_valid (v1), .o_ready (o_ready1), .o_data (o_data1), .o_field (o_field1),
    .o_valid (o_valid1), .i_ready (i_ready), .o_err (o_err1),
    .o_err_count (o_cnt1), .i_err_clear (i_err_clear)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_field(input logic [1:0] f);
    case (f)
      2'd1:    return 4'h3;
      2'd2:    return 4'h5;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic is_match(input logic [1:0] f);
    return (f == 2'd1) || (f == 2'd2);
  endfunction

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard and output monitor, sampled on the falling edge.
  logic [11:0] sb [2][$];
  logic [1:0]  ov, ordy, vin;
  logic [11:0] oout [2];
  logic [11:0] prev_out [2];
  logic [1:0]  prev_stall = '0;

  assign ov      = {o_valid1, o_valid0};
  assign ordy    = {o_ready1, o_ready0};
  assign vin     = {v1, v0};
  assign oout[0] = {o_data0, o_field0};
  assign oout[1] = {o_data1, o_field1};

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k]) begin
          if (prev_stall[k]) check($sformatf("hold%0d", k), oout[k], prev_out[k]);
          if (i_ready) begin
            if (sb[k].size() == 0) check($sformatf("unexpected%0d", k), sb[k].size(), 1);
            else check($sformatf("out%0d", k), oout[k], sb[k].pop_front());
          end
        end
        prev_stall[k] = ov[k] && !i_ready;
        prev_out[k]   = oout[k];
        if (vin[k] && ordy[k] && (k == 0 || is_match(i_field)))
          sb[k].push_back({i_data, exp_field(i_field)});
      end
    end
  end

  initial begin
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; i_ready = 1'b1; i_err_clear = 1'b0;
    i_data = '0; i_field = '0;
    edge_tick();
    edge_tick();
    reset = 1'b0;
    mid();
    check("rst_valid0", o_valid0, 0);
    check("rst_ready0", o_ready0, 1);
    check("rst_err0", o_err0, 0);
    check("rst_cnt0", o_cnt0, 0);
    check("rst_valid1", o_valid1, 0);
    check("rst_ready1", o_ready1, 1);
    edge_tick();

    // 1: back-to-back matched beats
    v0 = 1'b1; i_data = 8'hA0; i_field = 2'd1;
    edge_tick();
    i_data = 8'hA1; i_field = 2'd2;
    mid(); check("t1_lat", o_valid0, 1);
    edge_tick();
    i_data = 8'hA2; i_field = 2'd1;
    mid(); check("t1_b2b1", o_valid0, 1);
    edge_tick();
    v0 = 1'b0;
    mid(); check("t1_b2b2", o_valid0, 1);
    edge_tick();
    mid(); check("t1_idle", o_valid0, 0); check("t1_err", o_err0, 0);
    edge_tick();

    // 2: duplicate OF value, lowest index wins
    v0 = 1'b1; i_data = 8'h22; i_field = 2'd1;
    edge_tick();
    v0 = 1'b0;
    mid(); check("t2_lowest", o_field0, 4'h3);
    edge_tick();

    // 3: stall fills skid, then drain in order
    i_ready = 1'b0;
    v0 = 1'b1; i_data = 8'hC0; i_field = 2'd2;
    mid(); check("t3_rdy_a", o_ready0, 1);
    edge_tick();
    i_data = 8'hC1; i_field = 2'd1;
    mid(); check("t3_rdy_b", o_ready0, 1); check("t3_valid", o_valid0, 1);
    edge_tick();
    i_data = 8'hC2; i_field = 2'd2;
    mid(); check("t3_full", o_ready0, 0); check("t3_head", o_data0, 8'hC0);
    edge_tick();
    mid(); check("t3_full2", o_ready0, 0);
    edge_tick();
    i_ready = 1'b1;
    mid(); check("t3_drain_rdy", o_ready0, 0);
    edge_tick();
    mid(); check("t3_ready_back", o_ready0, 1); check("t3_second", o_data0, 8'hC1);
    edge_tick();
    v0 = 1'b0;
    mid(); check("t3_third", o_data0, 8'hC2);
    edge_tick();
    mid(); check("t3_empty", o_valid0, 0);
    edge_tick();

    // 4: unmatched forwarded with default, count saturates
    v0 = 1'b1; i_data = 8'hB7; i_field = 2'd0;
    edge_tick();
    v0 = 1'b0;
    mid();
    check("t4_default", o_field0, 4'hF);
    check("t4_err", o_err0, 1);
    check("t4_cnt1", o_cnt0, 1);
    edge_tick();
    for (int i = 0; i < 5; i++) begin
      v0 = 1'b1; i_data = 8'h30 + 8'(i); i_field = (i % 2 == 1) ? 2'd3 : 2'd0;
      edge_tick();
    end
    v0 = 1'b0;
    mid(); check("t4_sat", o_cnt0, 3); check("t4_err_hold", o_err0, 1);
    edge_tick();
    i_err_clear = 1'b1;
    edge_tick();
    i_err_clear = 1'b0;
    mid(); check("t4_clr_cnt", o_cnt0, 0); check("t4_clr_err", o_err0, 0);
    edge_tick();

    // 5: drop mode
    v1 = 1'b1; i_data = 8'hD0; i_field = 2'd1;
    edge_tick();
    i_data = 8'hD1; i_field = 2'd0;
    mid(); check("t5_first", o_field1, 4'h3);
    edge_tick();
    i_data = 8'hD2; i_field = 2'd2;
    mid(); check("t5_drop", o_valid1, 0); check("t5_cnt", o_cnt1, 1); check("t5_err", o_err1, 1);
    edge_tick();
    v1 = 1'b0;
    mid(); check("t5_second", o_field1, 4'h5);
    edge_tick();
    v1 = 1'b1; i_data = 8'hD3; i_field = 2'd3; i_err_clear = 1'b1;
    edge_tick();
    v1 = 1'b0; i_err_clear = 1'b0;
    mid(); check("t5_clr_err", o_err1, 0); check("t5_clr_cnt", o_cnt1, 0);
    check("t5_clr_drop", o_valid1, 0);
    edge_tick();
    v1 = 1'b1; i_data = 8'hD4; i_field = 2'd0;
    edge_tick();
    v1 = 1'b0;
    mid(); check("t5_recount", o_cnt1, 1);
    edge_tick();

    // 6: reset while FULL discards buffered beats and errors
    i_ready = 1'b0;
    v0 = 1'b1; i_data = 8'hE0; i_field = 2'd1;
    edge_tick();
    i_data = 8'hE1; i_field = 2'd0;
    edge_tick();
    v0 = 1'b0;
    mid(); check("t6_full", o_ready0, 0); check("t6_err", o_err0, 1);
    edge_tick();
    reset = 1'b1;
    sb[0].delete();
    edge_tick();
    reset = 1'b0; i_ready = 1'b1;
    mid();
    check("t6_valid", o_valid0, 0);
    check("t6_ready", o_ready0, 1);
    check("t6_err_clr", o_err0, 0);
    check("t6_cnt_clr", o_cnt0, 0);
    edge_tick();
    v0 = 1'b1; i_data = 8'hF0; i_field = 2'd2;
    edge_tick();
    i_data = 8'hF1; i_field = 2'd1;
    edge_tick();
    v0 = 1'b0;
    edge_tick();
    edge_tick();
    mid();
    check("sb_drain0", sb[0].size(), 0);
    check("sb_drain1", sb[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
